piso_shift_tx: RTL and testbench

//   Parallel-in/serial-out transmitter: accepts a WIDTH-bit word via a ready/valid

---
 rtl/shift_pkg.sv | 13 +
 rtl/piso_bit_counter.sv | 30 +++
 rtl/piso_shift_tx.sv | 113 +++++++++++
 tb/tb_piso_shift_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared state encodings and sizing helper for the serial transmitter.
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter with synchronous clear/increment and terminal-count flag.
module piso_bit_counter
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic incr,
  output logic tc
);

  localparam int CW = cnt_w(N);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (incr) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == CW'(N - 1));

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter with ready/valid load handshake.
// Define PIPO_PARITY_EN to append an even-parity bit after the data bits.
module piso_shift_tx
  import shift_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             q,
  output logic             bit_valid,
  output logic             done
);

`ifdef PIPO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif

  state_t state, state_nx;

  logic             accept;
  logic             adv;
  logic             fin;
  logic             tc;
  logic [WIDTH-1:0] ordered;
  logic [N-1:0]     frame;
  logic [N-1:0]     sreg;

  piso_bit_counter #(
    .N (N)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .incr  (adv & ~tc),
    .tc    (tc)
  );

  // Frame is laid out so that its top bit always goes out first.
  always_comb begin
    ordered = load_data;
    if (!MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        ordered[i] = load_data[WIDTH-1-i];
      end
    end
`ifdef PIPO_PARITY_EN
    frame = {ordered, ^load_data};
`else
    frame = ordered;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    adv      = 1'b0;
    fin      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        accept = load_valid;
        if (load_valid) begin
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        adv = enable;
        if (enable && tc) begin
          fin      = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= IDLE_LEVEL;
      sreg <= '0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (accept) begin
        q    <= frame[N-1];
        sreg <= {frame[N-2:0], 1'b0};
      end else if (adv) begin
        q    <= tc ? IDLE_LEVEL : sreg[N-1];
        sreg <= {sreg[N-2:0], 1'b0};
      end
    end
  end

  assign load_ready = (state == ST_IDLE);
  assign bit_valid  = (state == ST_SHIFT);

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: directed frames plus random traffic
// checked every cycle against a frame/index reference model.
module tb_piso_shift_tx;

`ifdef PIPO_PARITY_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;

  logic ready1, q1, bv1, done1;
  logic ready2, q2, bv2, done2;

  int checks = 0;
  int errors = 0;
  bit go = 1'b0;

  always #5 clk = ~clk;

  piso_shift_tx dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (ready1),
    .q          (q1),
    .bit_valid  (bv1),
    .done       (done1)
  );

  piso_shift_tx #(
    .WIDTH      (8),
    .MSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b1)
  ) dut2 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (ready2),
    .q          (q2),
    .bit_valid  (bv2),
    .done       (done2)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bitof(input logic [7:0] w, input int i, input bit msb);
    if (i >= 8) return ^w;
    return msb ? w[7-i] : w[i];
  endfunction

  // Reference: a frame is either in flight (word + bit index) or not.
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  int         m_idx = 0;
  logic [7:0] m_word = 8'h00;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_idx  <= 0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (load_valid) begin
        m_busy <= 1'b1;
        m_word <= load_data;
        m_idx  <= 0;
      end
    end else begin
      m_done <= 1'b0;
      if (enable) begin
        if (m_idx == N - 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_idx <= m_idx + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("m_q1", q1, m_busy ? bitof(m_word, m_idx, 1'b1) : 1'b0);
      chk("m_q2", q2, m_busy ? bitof(m_word, m_idx, 1'b0) : 1'b1);
      chk("m_bv1", bv1, m_busy);
      chk("m_bv2", bv2, m_busy);
      chk("m_rdy1", ready1, !m_busy);
      chk("m_rdy2", ready2, !m_busy);
      chk("m_done1", done1, m_done);
      chk("m_done2", done2, m_done);
    end
  end

  task automatic accept(input logic [7:0] d);
    chk("acc_ready", ready1, 1'b1);
    load_valid = 1'b1;
    load_data  = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!ready1 && n < 200) begin
      enable = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", ready1, 1'b1);
  endtask

  logic [7:0] lit;
  int         bvc;
  bit         seen;

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    go    = 1'b1;
    chk("rst_q1", q1, 1'b0);
    chk("rst_q2", q2, 1'b1);
    chk("rst_rdy", ready1, 1'b1);
    chk("rst_bv", bv1, 1'b0);
    chk("rst_done", done1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      enable = k[0];
      @(negedge clk);
      chk("idle_q2", q2, 1'b1);
      chk("idle_bv2", bv2, 1'b0);
    end

    // A5 with enable held high
    enable = 1'b1;
    lit = 8'hA5;
    accept(8'hA5);
    for (int c = 1; c <= 8; c++) begin
      chk("t1_q", q1, lit[8-c]);
      chk("t1_bv", bv1, 1'b1);
      chk("t1_done", done1, 1'b0);
      @(negedge clk);
    end
`ifdef PIPO_PARITY_EN
    chk("t1_par", q1, 1'b0);
    @(negedge clk);
`endif
    chk("t1_done_pulse", done1, 1'b1);
    chk("t1_ready_back", ready1, 1'b1);
    @(negedge clk);
    chk("t1_done_clr", done1, 1'b0);

    // A5 LSB-first on dut2, enable every 3rd cycle
    enable = 1'b0;
    accept(8'hA5);
    bvc  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (bv2) begin
        bvc++;
        if ((k - 1) / 3 < 8)
          chk("t2_q", q2, lit[(k-1)/3]);
      end
      if (done2) seen = 1'b1;
      enable = (k % 3 == 0);
      @(negedge clk);
    end
    chk("t2_done_seen", seen, 1'b1);
    chk("t2_bv_24", bvc == 3 * N, 1'b1);

    // FF with an ignored load pulse mid-frame
    wait_idle();
    enable = 1'b1;
    accept(8'hFF);
    for (int c = 1; c <= 8; c++) begin
      chk("t3_q", q1, 1'b1);
      chk("t3_rdy", ready1, 1'b0);
      load_valid = (c == 3);
      load_data  = 8'h00;
      @(negedge clk);
    end
    load_valid = 1'b0;
    wait_idle();

    // C3 aborted by reset, then 01 sent cleanly
    accept(8'hC3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4_q", q1, 1'b0);
    chk("t4_q2", q2, 1'b1);
    chk("t4_bv", bv1, 1'b0);
    chk("t4_rdy", ready1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      chk("t4_nodone", done1, 1'b0);
      @(negedge clk);
    end
    lit = 8'h01;
    accept(8'h01);
    for (int c = 1; c <= 8; c++) begin
      chk("t4_q01", q1, lit[8-c]);
      @(negedge clk);
    end
`ifdef PIPO_PARITY_EN
    chk("t4_par01", q1, 1'b1);
    @(negedge clk);
`endif
    chk("t4_done", done1, 1'b1);

`ifdef PIPO_PARITY_EN
    @(negedge clk);
    accept(8'h07);
    repeat (8) @(negedge clk);
    chk("par_07", q1, 1'b1);
    @(negedge clk);
    chk("par_done10", done1, 1'b1);
`endif

    // random traffic
    for (int k = 0; k < 600; k++) begin
      reset      = ($urandom_range(0, 99) == 0);
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 8'($urandom);
      enable     = ($urandom_range(0, 9) < 7);
      @(negedge clk);
    end
    reset      = 1'b0;
    load_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
